// File: rtl/dmem_responder_pkg.sv
`default_nettype none
// ============================================================================
// Module      : dmem_responder_pkg
// Description : Size encodings, FSM states and the default memory base
//               shared by the data-memory responder and the IFU.
// Revision    : 1.0 - initial release
// ============================================================================
package dmem_responder_pkg;

    localparam logic [1:0] SZ_B = 2'd0;
    localparam logic [1:0] SZ_H = 2'd1;
    localparam logic [1:0] SZ_W = 2'd2;
    localparam logic [1:0] SZ_D = 2'd3;

    // Byte address of word 0; the IFU resets its PC to the same value.
    localparam logic [63:0] DMEM_BASE = 64'h0000_0000_8000_0000;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

    function automatic logic [63:0] size_mask(input logic [1:0] size);
        logic [63:0] m;
        case (size)
            SZ_B:    m = 64'h0000_0000_0000_00FF;
            SZ_H:    m = 64'h0000_0000_0000_FFFF;
            SZ_W:    m = 64'h0000_0000_FFFF_FFFF;
            default: m = 64'hFFFF_FFFF_FFFF_FFFF;
        endcase
        return m;
    endfunction

endpackage
`default_nettype wire

// File: rtl/dmem_responder_if.sv
`default_nettype none
// ============================================================================
// Module      : dmem_responder_if
// Description : Valid/ready load/store request and response bundle.
// Revision    : 1.0 - initial release
// ============================================================================
interface dmem_responder_if;

    logic        req_valid;
    logic        req_ready;
    logic [63:0] req_addr;
    logic        req_wen;
    logic [1:0]  req_size;
    logic [63:0] req_wdata;
    logic        resp_valid;
    logic        resp_ready;
    logic [63:0] resp_rdata;
    logic        resp_err;

    modport master (
        output req_valid, req_addr, req_wen, req_size, req_wdata, resp_ready,
        input  req_ready, resp_valid, resp_rdata, resp_err
    );

    modport slave (
        input  req_valid, req_addr, req_wen, req_size, req_wdata, resp_ready,
        output req_ready, resp_valid, resp_rdata, resp_err
    );

endinterface
`default_nettype wire

// File: rtl/dmem_responder_array.sv
`default_nettype none
// ============================================================================
// Module      : dmem_array
// Description : DEPTH x 64-bit byte-enabled storage, one synchronous port.
// Revision    : 1.0 - initial release
// ============================================================================
module dmem_array #(
    parameter int DEPTH = 1024
) (
    input  logic                     clk,
    input  logic                     en,
    input  logic                     we,
    input  logic [7:0]               be,
    input  logic [$clog2(DEPTH)-1:0] idx,
    input  logic [63:0]              wdata,
    output logic [63:0]              rdata
);

    logic [63:0] r_mem [DEPTH];

    // Read returns the pre-write word; stores ignore it.
    always_ff @(posedge clk) begin
        if (en) begin
            rdata <= r_mem[idx];
            if (we) begin
                for (int i = 0; i < 8; i++) begin
                    if (be[i]) begin
                        r_mem[idx][8*i +: 8] <= wdata[8*i +: 8];
                    end
                end
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/dmem_responder.sv
`default_nettype none
// ============================================================================
// Module      : dmem_responder
// Description : Single-outstanding valid/ready load/store responder with a
//               programmable latency in front of a byte-enabled word array.
// Revision    : 1.0 - initial release
// ============================================================================
module dmem_responder
    import dmem_responder_pkg::*;
#(
    parameter int          DEPTH   = 1024,
    parameter logic [63:0] BASE    = DMEM_BASE,
    parameter int          LATENCY = 2
) (
    input  logic            clk,
    input  logic            rst,
    dmem_responder_if.slave bus
);

    localparam int          c_IDXW     = $clog2(DEPTH);
    localparam logic [63:0] c_SPAN     = 64'(DEPTH) * 64'd8;
    localparam logic [3:0]  c_CNT_INIT = 4'(LATENCY - 1);
    localparam bit          c_DIRECT   = (LATENCY == 1);

    state_t              r_state, w_state_nxt;
    logic [3:0]          r_cnt, w_cnt_nxt;
    logic                w_exec;

    logic                r_wen, r_err;
    logic [2:0]          r_off;
    logic [1:0]          r_size;
    logic [7:0]          r_be;
    logic [c_IDXW-1:0]   r_idx;
    logic [63:0]         r_wdata;

    logic                w_accept;
    logic [2:0]          w_off;
    logic [3:0]          w_nbytes;
    logic [63:0]         w_rel;
    logic                w_err;
    logic [7:0]          w_mask8, w_be;
    logic [c_IDXW-1:0]   w_idx;
    logic [63:0]         w_wdata_sh;

    logic                w_x_err, w_x_wen;
    logic [7:0]          w_x_be;
    logic [c_IDXW-1:0]   w_x_idx;
    logic [63:0]         w_x_wdata;
    logic [63:0]         w_arr_rdata;

    assign w_accept   = bus.req_valid && (r_state == IDLE);
    assign w_off      = bus.req_addr[2:0];
    assign w_nbytes   = 4'd1 << bus.req_size;
    assign w_rel      = bus.req_addr - BASE;
    assign w_err      = (bus.req_addr < BASE) || (w_rel >= c_SPAN) ||
                        ((4'({1'b0, w_off}) + w_nbytes) > 4'd8);
    assign w_mask8    = 8'((9'd1 << w_nbytes) - 9'd1);
    assign w_be       = w_mask8 << w_off;
    assign w_idx      = w_rel[c_IDXW+2:3];
    assign w_wdata_sh = bus.req_wdata << {w_off, 3'b000};

    // With a one-cycle latency the access executes on the accept edge, so
    // the array must see the live request instead of the latched copy.
    assign w_x_err   = (r_state == IDLE) ? w_err       : r_err;
    assign w_x_wen   = (r_state == IDLE) ? bus.req_wen : r_wen;
    assign w_x_be    = (r_state == IDLE) ? w_be        : r_be;
    assign w_x_idx   = (r_state == IDLE) ? w_idx       : r_idx;
    assign w_x_wdata = (r_state == IDLE) ? w_wdata_sh  : r_wdata;

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_exec      = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_accept) begin
                    if (c_DIRECT) begin
                        w_state_nxt = RESP;
                        w_exec      = 1'b1;
                    end else begin
                        w_state_nxt = WAIT;
                        w_cnt_nxt   = c_CNT_INIT;
                    end
                end
            end
            WAIT: begin
                // Leaving on the count-1 edge places resp_valid LATENCY
                // cycles after acceptance.
                if (r_cnt <= 4'd1) begin
                    w_state_nxt = RESP;
                    w_cnt_nxt   = 4'd0;
                    w_exec      = 1'b1;
                end else begin
                    w_cnt_nxt = r_cnt - 4'd1;
                end
            end
            RESP: begin
                if (bus.resp_ready) begin
                    w_state_nxt = IDLE;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
            r_cnt   <= 4'd0;
            r_wen   <= 1'b0;
            r_err   <= 1'b0;
            r_off   <= 3'd0;
            r_size  <= 2'd0;
            r_be    <= 8'd0;
            r_idx   <= '0;
            r_wdata <= 64'd0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            if (w_accept) begin
                r_wen   <= bus.req_wen;
                r_err   <= w_err;
                r_off   <= w_off;
                r_size  <= bus.req_size;
                r_be    <= w_be;
                r_idx   <= w_idx;
                r_wdata <= w_wdata_sh;
            end
        end
    end

    dmem_array #(
        .DEPTH (DEPTH)
    ) u_array (
        .clk   (clk),
        .en    (w_exec && !w_x_err),
        .we    (w_x_wen),
        .be    (w_x_be),
        .idx   (w_x_idx),
        .wdata (w_x_wdata),
        .rdata (w_arr_rdata)
    );

    assign bus.req_ready  = (r_state == IDLE);
    assign bus.resp_valid = (r_state == RESP);
    assign bus.resp_err   = (r_state == RESP) && r_err;
    assign bus.resp_rdata = ((r_state == RESP) && !r_err && !r_wen) ?
                            ((w_arr_rdata >> {r_off, 3'b000}) & size_mask(r_size)) :
                            64'd0;

endmodule
`default_nettype wire

// File: tb/tb_dmem_responder.sv
`default_nettype none
// ============================================================================
// Module      : tb_dmem_responder
// Description : Directed bench for dmem_responder with a byte-level memory
//               model and a per-cycle response checker.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_dmem_responder;
    import dmem_responder_pkg::*;

    localparam logic [63:0] BASE  = 64'h8000_0000;
    localparam int          DEPTH = 1024;
    localparam int          LAT   = 2;

    typedef struct {
        logic [63:0] addr;
        logic        wen;
        logic [1:0]  size;
        logic [63:0] wdata;
    } req_t;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    dmem_responder_if bus ();
    dmem_responder_if b1 ();
    dmem_responder_if b15 ();

    dmem_responder #(.DEPTH(DEPTH), .BASE(BASE), .LATENCY(LAT)) dut (
        .clk(clk), .rst(rst), .bus(bus));
    dmem_responder #(.DEPTH(DEPTH), .BASE(BASE), .LATENCY(1)) dut_l1 (
        .clk(clk), .rst(rst), .bus(b1));
    dmem_responder #(.DEPTH(DEPTH), .BASE(BASE), .LATENCY(15)) dut_l15 (
        .clk(clk), .rst(rst), .bus(b15));

    int vectors = 0;
    int fails   = 0;
    int ncyc    = 0;
    always @(posedge clk) ncyc <= ncyc + 1;

    logic [7:0]  mem_m [logic [63:0]];
    bit          chk_en   = 1'b0;
    bit          exp_live = 1'b0;
    bit          seen     = 1'b0;
    int          acc_n    = 0;
    logic [63:0] exp_rdata;
    logic        exp_err;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        vectors++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, req, $time);
        end
    endtask

    function automatic void model(input req_t r, output logic [63:0] rd, output logic er);
        int          nb;
        logic [63:0] off;
        nb  = 1 << r.size;
        off = r.addr % 64'd8;
        er  = (r.addr < BASE) || ((r.addr - BASE) >= 64'(DEPTH * 8)) || (off + 64'(nb) > 64'd8);
        rd  = 64'd0;
        if (!er && !r.wen) begin
            for (int i = 0; i < nb; i++) begin
                rd[8*i +: 8] = mem_m.exists(r.addr + 64'(i)) ? mem_m[r.addr + 64'(i)] : 8'hxx;
            end
        end
    endfunction

    // Per-cycle checker for the main responder.
    always @(negedge clk) begin
        if (chk_en) begin
            if (!exp_live) begin
                chk("idle_req_ready", 64'(bus.req_ready), 64'd1);
                chk("idle_resp_valid", 64'(bus.resp_valid), 64'd0);
            end else begin
                chk("busy_req_ready", 64'(bus.req_ready), 64'd0);
                if (bus.resp_valid === 1'b1) begin
                    if (!seen) begin
                        chk("latency", 64'(ncyc - acc_n), 64'(LAT - 1));
                        seen = 1'b1;
                    end
                    chk("resp_rdata", bus.resp_rdata, exp_rdata);
                    chk("resp_err", 64'(bus.resp_err), 64'(exp_err));
                end else if (seen || (ncyc - acc_n >= LAT - 1)) begin
                    chk("resp_valid_held", 64'(bus.resp_valid), 64'd1);
                end
            end
        end
    end

    task automatic issue(input req_t r, input int stall, input req_t cv,
                         input bit lit, input logic [63:0] lit_rd, input logic lit_err);
        int guard;
        @(negedge clk); #1;
        bus.req_valid = 1'b1;
        bus.req_addr  = r.addr;
        bus.req_wen   = r.wen;
        bus.req_size  = r.size;
        bus.req_wdata = r.wdata;
        guard = 0;
        while (bus.req_ready !== 1'b1 && guard <= 40) begin
            @(negedge clk); #1;
            guard++;
        end
        if (guard > 40) chk("accept_timeout", 64'(bus.req_ready), 64'd1);
        model(r, exp_rdata, exp_err);
        @(posedge clk); #1;
        acc_n = ncyc;
        seen = 1'b0;
        exp_live = 1'b1;
        bus.req_valid = 1'b0;
        bus.resp_ready = (stall == 0);
        guard = 0;
        while (!seen && exp_live) begin
            @(negedge clk); #1;
            guard++;
            if (guard > 40) begin
                chk("resp_timeout", 64'(bus.resp_valid), 64'd1);
                exp_live = 1'b0;
            end
        end
        if (exp_live && lit) begin
            chk("literal_rdata", bus.resp_rdata, lit_rd);
            chk("literal_err", 64'(bus.resp_err), 64'(lit_err));
        end
        if (stall > 0) begin
            bus.req_valid = 1'b1;
            bus.req_addr  = cv.addr;
            bus.req_wen   = cv.wen;
            bus.req_size  = cv.size;
            bus.req_wdata = cv.wdata;
            repeat (stall) @(negedge clk);
            #1 bus.resp_ready = 1'b1;
        end
        @(posedge clk); #1;
        if (exp_live && r.wen && !exp_err) begin
            for (int i = 0; i < (1 << r.size); i++) mem_m[r.addr + 64'(i)] = r.wdata[8*i +: 8];
        end
        exp_live = 1'b0;
    endtask

    task automatic probe(input bit wen, input logic [63:0] d);
        int          l1, l15, a;
        logic [63:0] want;
        l1 = -1; l15 = -1;
        want = wen ? 64'd0 : d;
        @(negedge clk); #1;
        b1.req_valid = 1'b1;  b1.req_addr = BASE + 64'h40;  b1.req_wen = wen;
        b1.req_size = SZ_D;   b1.req_wdata = d;
        b15.req_valid = 1'b1; b15.req_addr = BASE + 64'h40; b15.req_wen = wen;
        b15.req_size = SZ_D;  b15.req_wdata = d;
        @(posedge clk); #1;
        a = ncyc;
        b1.req_valid = 1'b0;
        b15.req_valid = 1'b0;
        for (int k = 0; k < 30; k++) begin
            @(negedge clk);
            if (l1 < 0 && b1.resp_valid === 1'b1) begin
                l1 = ncyc - a;
                chk("lat1_rdata", b1.resp_rdata, want);
            end
            if (l15 < 0 && b15.resp_valid === 1'b1) begin
                l15 = ncyc - a;
                chk("lat15_rdata", b15.resp_rdata, want);
            end
        end
        chk("lat1_cycles", 64'(l1 + 1), 64'd1);
        chk("lat15_cycles", 64'(l15 + 1), 64'd15);
    endtask

    req_t none = '{addr: 64'd0, wen: 1'b0, size: 2'd0, wdata: 64'd0};

    function automatic req_t mk(input logic [63:0] a, input logic w, input logic [1:0] s,
                                input logic [63:0] d);
        req_t r;
        r.addr = a; r.wen = w; r.size = s; r.wdata = d;
        return r;
    endfunction

    initial begin
        bus.req_valid = 1'b0; bus.req_addr = 64'd0; bus.req_wen = 1'b0;
        bus.req_size = 2'd0;  bus.req_wdata = 64'd0; bus.resp_ready = 1'b1;
        b1.req_valid = 1'b0;  b1.req_addr = 64'd0;  b1.req_wen = 1'b0;
        b1.req_size = 2'd0;   b1.req_wdata = 64'd0; b1.resp_ready = 1'b1;
        b15.req_valid = 1'b0; b15.req_addr = 64'd0; b15.req_wen = 1'b0;
        b15.req_size = 2'd0;  b15.req_wdata = 64'd0; b15.resp_ready = 1'b1;
        #2 rst = 1'b1;
        repeat (3) @(negedge clk);
        chk("rst_req_ready", 64'(bus.req_ready), 64'd1);
        chk("rst_resp_valid", 64'(bus.resp_valid), 64'd0);
        chk("rst_resp_rdata", bus.resp_rdata, 64'd0);
        chk("rst_resp_err", 64'(bus.resp_err), 64'd0);
        #1 rst = 1'b0;
        chk_en = 1'b1;

        issue(mk(64'h8000_0010, 1, SZ_D, 64'h1122_3344_5566_7788), 0, none, 1, 64'd0, 1'b0);
        issue(mk(64'h8000_0010, 0, SZ_D, 64'd0), 0, none, 1, 64'h1122_3344_5566_7788, 1'b0);
        issue(mk(64'h8000_0013, 1, SZ_B, 64'hAB), 0, none, 1, 64'd0, 1'b0);
        issue(mk(64'h8000_0010, 0, SZ_D, 64'd0), 0, none, 1, 64'h1122_3344_AB66_7788, 1'b0);
        issue(mk(64'h8000_0016, 0, SZ_H, 64'd0), 0, none, 1, 64'h1122, 1'b0);
        issue(mk(64'h8000_0006, 0, SZ_W, 64'd0), 0, none, 1, 64'd0, 1'b1);
        issue(mk(64'h8000_0000, 1, SZ_D, 64'hCAFE_F00D_DEAD_BEEF), 0, none, 1, 64'd0, 1'b0);
        issue(mk(64'h7FFF_FFF8, 1, SZ_D, 64'h0BAD_0BAD_0BAD_0BAD), 0, none, 1, 64'd0, 1'b1);
        issue(mk(64'h8000_0000, 0, SZ_D, 64'd0), 0, none, 1, 64'hCAFE_F00D_DEAD_BEEF, 1'b0);
        issue(mk(64'h8000_1FF8, 1, SZ_D, 64'h0102_0304_0506_0708), 0, none, 0, 64'd0, 1'b0);
        issue(mk(64'h8000_1FFC, 0, SZ_W, 64'd0), 0, none, 1, 64'h0102_0304, 1'b0);
        issue(mk(64'h8000_2000, 0, SZ_D, 64'd0), 0, none, 1, 64'd0, 1'b1);
        issue(mk(64'h8000_0024, 1, SZ_W, 64'hFFFF_FFFF_0A0B_0C0D), 0, none, 0, 64'd0, 1'b0);
        issue(mk(64'h8000_0025, 0, SZ_B, 64'd0), 0, none, 1, 64'h0C, 1'b0);
        issue(mk(64'h8000_0001, 1, SZ_D, 64'h1), 0, none, 1, 64'd0, 1'b1);

        // Stalled response with a competing request held on the bus.
        issue(mk(64'h8000_0010, 0, SZ_D, 64'd0), 5, mk(64'h8000_0017, 0, SZ_B, 64'd0),
              1, 64'h1122_3344_AB66_7788, 1'b0);
        issue(mk(64'h8000_0017, 0, SZ_B, 64'd0), 0, none, 1, 64'h11, 1'b0);

        // Reset while a store waits: the store must vanish.
        @(negedge clk); #1;
        bus.req_valid = 1'b1; bus.req_addr = 64'h8000_0010; bus.req_wen = 1'b1;
        bus.req_size = SZ_D;  bus.req_wdata = 64'hDEAD_DEAD_DEAD_DEAD;
        @(posedge clk); #1;
        chk("rst_wait_accepted", 64'(bus.req_ready), 64'd0);
        rst = 1'b1;
        bus.req_valid = 1'b0;
        @(negedge clk); #1;
        rst = 1'b0;
        chk("rst_wait_ready", 64'(bus.req_ready), 64'd1);
        issue(mk(64'h8000_0010, 0, SZ_D, 64'd0), 0, none, 1, 64'h1122_3344_AB66_7788, 1'b0);

        probe(1'b1, 64'h5A5A_0123_4567_89AB);
        probe(1'b0, 64'h5A5A_0123_4567_89AB);

        repeat (3) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
        $finish;
    end

endmodule
`default_nettype wire
